cla_nibble_seq_ctrl: RTL and testbench



---
 rtl/cla_seq_pkg.sv | 16 +
 rtl/cla_seq_nibble_sel.sv | 26 ++
 rtl/cla_nibble_seq_ctrl.sv | 118 +++++++++++
 tb/tb_cla_nibble_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared state encoding and nibble constants for the CLA nibble sequencer
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/cla_seq_nibble_sel.sv
// rtl/cla_seq_nibble_sel.sv - selects the current operand nibbles for the external CLA slice
module cla_seq_nibble_sel
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = 2
) (
    input  logic                en_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [NIBBLE_W-1:0] a_o,
    output logic [NIBBLE_W-1:0] b_o
);

    // Forced to zero outside RUN so the slice inputs only move while it is in use.
    always_comb begin
        a_o = '0;
        b_o = '0;
        if (en_i) begin
            a_o = a_i[NIBBLE_W*idx_i +: NIBBLE_W];
            b_o = b_i[NIBBLE_W*idx_i +: NIBBLE_W];
        end
    end

endmodule

// File: rtl/cla_nibble_seq_ctrl.sv
// rtl/cla_nibble_seq_ctrl.sv - WIDTH-bit adder sequencing one external 4-bit CLA slice, LSB nibble first
// Optional signed-overflow output enabled by CLA_SEQ_OVERFLOW_EN.
module cla_nibble_seq_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] slice_a,
    output logic [NIBBLE_W-1:0] slice_b,
    output logic                slice_c0,
    input  logic [NIBBLE_W-1:0] slice_s,
    input  logic                slice_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    sum,
    output logic                cout,
    output logic                busy
`ifdef CLA_SEQ_OVERFLOW_EN
    ,
    output logic                ovf
`endif
);

    localparam int NIBBLES = nibbles(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
        $error("cla_nibble_seq_ctrl: WIDTH must be a positive multiple of 4");
    end

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
`ifdef CLA_SEQ_OVERFLOW_EN
    logic               ovf_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= slice_s;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(NIBBLES - 1)) begin
                        cout_q  <= slice_cout;
`ifdef CLA_SEQ_OVERFLOW_EN
                        // Carry into the MSB differs from carry out of it.
                        ovf_q   <= slice_cout ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[NIBBLE_W-1]);
`endif
                        idx_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    cla_seq_nibble_sel #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_nibble_sel (
        .en_i  (state_q == RUN),
        .a_i   (a_q),
        .b_i   (b_q),
        .idx_i (idx_q),
        .a_o   (slice_a),
        .b_o   (slice_b)
    );

    assign slice_c0  = (state_q == RUN) & carry_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_SEQ_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// tb/tb_cla_nibble_seq_ctrl.sv - scoreboard bench for cla_nibble_seq_ctrl with a real 4-bit CLA slice
module tb_cla_nibble_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   slice_a;
    logic [3:0]   slice_b;
    logic         slice_c0;
    logic [3:0]   slice_s;
    logic         slice_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CLA_SEQ_OVERFLOW_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    logic [3:0] g, p;
    logic       c1, c2, c3, c4;
    always_comb begin
        g  = slice_a & slice_b;
        p  = slice_a ^ slice_b;
        c1 = g[0] | (p[0] & slice_c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & slice_c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & slice_c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & slice_c0);
        slice_s    = p ^ {c3, c2, c1, slice_c0};
        slice_cout = c4;
    end

    cla_nibble_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_c0   (slice_c0),
        .slice_s    (slice_s),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .busy       (busy)
`ifdef CLA_SEQ_OVERFLOW_EN
        ,
        .ovf        (ovf)
`endif
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_result(input exp_t e);
        check_eq("sum", 32'(sum), 32'(e.s));
        check_eq("cout", 32'(cout), 32'(e.c));
`ifdef CLA_SEQ_OVERFLOW_EN
        check_eq("ovf", 32'(ovf), 32'(e.v));
`endif
    endtask

    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input int stall);
        logic [W:0]   full;
        logic [W:0]   part;
        logic [W-1:0] m;
        exp_t         e;
        int           n;
        full = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
        @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        cin       = cv;
        out_ready = 1'b0;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && n <= 4) begin
                m    = W'((32'd1 << (4 * (n - 1))) - 32'd1);
                part = {1'b0, av & m} + {1'b0, bv & m} + (W+1)'(cv);
                check_eq("slice_a", 32'(slice_a), 32'((av >> (4 * (n - 1))) & 16'hF));
                check_eq("slice_b", 32'(slice_b), 32'((bv >> (4 * (n - 1))) & 16'hF));
                check_eq("slice_c0", 32'(slice_c0), 32'(part[4 * (n - 1)]));
                check_eq("busy_run", 32'(busy), 32'd1);
                check_eq("in_ready_run", 32'(in_ready), 32'd0);
            end
        end while (!out_valid && n < 12);
        check_eq("latency", 32'(n), 32'd5);
        if (!out_valid) begin
            check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
            void'(sb_q.pop_front());
            in_valid = 1'b0;
            return;
        end
        for (int s = 0; s < stall; s++) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_busy", 32'(busy), 32'd1);
            check_result(sb_q[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check_eq("hs_in_ready", 32'(in_ready), 32'd0);
        check_result(sb_q.pop_front());
        @(negedge clk);
        check_eq("post_out_valid", 32'(out_valid), 32'd0);
        check_eq("post_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_slice", 32'({slice_a, slice_b, slice_c0}), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        run_add(16'h1234, 16'h4321, 1'b0, 0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 0);
        run_add(16'h0000, 16'h0000, 1'b1, 0);
        run_add(16'h1234, 16'h4321, 1'b0, 3);

        // Abort an addition during its second RUN cycle.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h4321;
        cin      = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_slice", 32'({slice_a, slice_b, slice_c0}), 32'd0);
        check_eq("mid_rst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        run_add(16'h00FF, 16'h0001, 1'b0, 0);

        run_add(16'h7FFF, 16'h0001, 1'b0, 0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 1);
        run_add(16'h8000, 16'h8000, 1'b1, 0);
        for (int i = 0; i < 6; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
